mac_seq_multiply: RTL and testbench

- Parametrised, iterative signed/unsigned integer multiplier for the MAC datapath.
- Successor to the combinational array multiplier. It trades area for latency by retiring BITS_PER_CYCLE multiplier bits per clock.
- Valid/ready handshakes on both sides, so it drops directly between the operand registers and the accumulator stage.

---
 rtl/mac_seq_multiply_pkg.sv | 7 +
 rtl/mac_mul_step.sv | 21 ++
 rtl/mac_seq_multiply.sv | 83 ++++++++
 tb/tb_mac_seq_multiply.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/mac_seq_multiply_pkg.sv
// mac_seq_multiply_pkg: shared FSM encoding and counter sizing helper for the sequential multiplier
package mac_seq_multiply_pkg;
  typedef enum logic [1:0] {MUL_IDLE, MUL_BUSY, MUL_DONE} mul_state_t;
  function automatic int cnt_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/mac_mul_step.sv
// mac_mul_step: one radix-2^BPC partial-product step on a right-aligned accumulator (acc_next = acc/2^BPC + digit*a*2^(W-BPC), top bit of a signed B subtracts)
module mac_mul_step #(
  parameter int W = 8,
  parameter int BPC = 2
) (
  input  logic [W:0]     a,
  input  logic [BPC-1:0] digit,
  input  logic           top,
  input  logic           sign,
  input  logic [2*W:0]   acc,
  output logic [2*W:0]   nxt
);
  logic [2*W:0] ax;
  assign ax = {{W{a[W]}}, a};
  always_comb begin
    nxt = $signed(acc) >>> BPC;
    for (int i = 0; i < BPC; i++)
      if (digit[i])
        nxt = (top && sign && i == BPC - 1) ? nxt - (ax << (W - BPC + i)) : nxt + (ax << (W - BPC + i));
  end
endmodule

// File: rtl/mac_seq_multiply.sv
// mac_seq_multiply: iterative signed/unsigned W x W multiplier retiring BITS_PER_CYCLE multiplier bits per clock with valid/ready handshakes
module mac_seq_multiply
  import mac_seq_multiply_pkg::*;
#(
  parameter int MAC_MIN_WIDTH = 8,
  parameter int MAC_MULT_WIDTH = 2 * MAC_MIN_WIDTH,
  parameter int BITS_PER_CYCLE = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      sign,
  input  logic [MAC_MIN_WIDTH-1:0]  A,
  input  logic [MAC_MIN_WIDTH-1:0]  B,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [MAC_MULT_WIDTH-1:0] C,
  output logic                      busy
);
  localparam int W = MAC_MIN_WIDTH;
  localparam int N_ITER = W / BITS_PER_CYCLE;
  localparam int CW = cnt_w(N_ITER);
  mul_state_t state;
  logic [CW-1:0] cnt;
  logic [W:0] a_r;
  logic [W-1:0] b_r;
  logic sign_r, last;
  logic [2*W:0] acc, nxt;
  assign last = cnt == CW'(N_ITER - 1);
  mac_mul_step #(.W(W), .BPC(BITS_PER_CYCLE)) u_step (
    .a(a_r),
    .digit(b_r[BITS_PER_CYCLE-1:0]),
    .top(last),
    .sign(sign_r),
    .acc(acc),
    .nxt(nxt)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= MUL_IDLE;
      in_ready <= 1'b1;
      out_valid <= 1'b0;
      busy <= 1'b0;
      C <= '0;
      cnt <= '0;
      a_r <= '0;
      b_r <= '0;
      sign_r <= 1'b0;
      acc <= '0;
    end else
      case (state)
        MUL_IDLE:
          if (in_valid) begin
            a_r <= {sign & A[W-1], A};
            b_r <= B;
            sign_r <= sign;
            acc <= '0;
            cnt <= '0;
            state <= MUL_BUSY;
            in_ready <= 1'b0;
            busy <= 1'b1;
          end
        MUL_BUSY: begin
          acc <= nxt;
          b_r <= b_r >> BITS_PER_CYCLE;
          cnt <= cnt + 1'b1;
          if (last) begin
            C <= nxt[2*W-1:0];
            state <= MUL_DONE;
            busy <= 1'b0;
            out_valid <= 1'b1;
          end
        end
        MUL_DONE:
          if (out_ready) begin
            state <= MUL_IDLE;
            out_valid <= 1'b0;
            in_ready <= 1'b1;
          end
        default: state <= MUL_IDLE;
      endcase
endmodule

// File: tb/tb_mac_seq_multiply.sv
// tb_mac_seq_multiply: directed self-checking bench for the sequential multiplier and a parameter sweep
module tb_mac_seq_multiply;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  int checks = 0, errors = 0;
  logic in_valid = 1'b0, sign = 1'b0, out_ready = 1'b0;
  logic [7:0] a = '0, b = '0;
  logic in_ready, out_valid, busy;
  logic [15:0] c;
  mac_seq_multiply #(.MAC_MIN_WIDTH(8), .BITS_PER_CYCLE(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .sign(sign),
    .A(a), .B(b), .out_valid(out_valid), .out_ready(out_ready), .C(c), .busy(busy)
  );
  logic sv = 1'b0, ss = 1'b0, sor = 1'b0;
  logic [7:0] sa = '0, sb = '0;
  logic [15:0] a16 = '0, b16 = '0;
  logic [3:0] sov, sir, sby;
  logic [15:0] sc [3];
  logic [31:0] sc16;
  mac_seq_multiply #(.MAC_MIN_WIDTH(8), .BITS_PER_CYCLE(1)) s1 (
    .clk(clk), .rst_n(rst_n), .in_valid(sv), .in_ready(sir[0]), .sign(ss),
    .A(sa), .B(sb), .out_valid(sov[0]), .out_ready(sor), .C(sc[0]), .busy(sby[0])
  );
  mac_seq_multiply #(.MAC_MIN_WIDTH(8), .BITS_PER_CYCLE(4)) s4 (
    .clk(clk), .rst_n(rst_n), .in_valid(sv), .in_ready(sir[1]), .sign(ss),
    .A(sa), .B(sb), .out_valid(sov[1]), .out_ready(sor), .C(sc[1]), .busy(sby[1])
  );
  mac_seq_multiply #(.MAC_MIN_WIDTH(8), .BITS_PER_CYCLE(8)) s8 (
    .clk(clk), .rst_n(rst_n), .in_valid(sv), .in_ready(sir[2]), .sign(ss),
    .A(sa), .B(sb), .out_valid(sov[2]), .out_ready(sor), .C(sc[2]), .busy(sby[2])
  );
  mac_seq_multiply #(.MAC_MIN_WIDTH(16), .BITS_PER_CYCLE(4)) s16 (
    .clk(clk), .rst_n(rst_n), .in_valid(sv), .in_ready(sir[3]), .sign(ss),
    .A(a16), .B(b16), .out_valid(sov[3]), .out_ready(sor), .C(sc16), .busy(sby[3])
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic run(input logic sg, input logic [7:0] av, input logic [7:0] bv, input logic [15:0] exp,
                     input int hold, input logic early, input string tag);
    int j;
    @(negedge clk);
    sign = sg;
    a = av;
    b = bv;
    in_valid = 1'b1;
    check({tag, "/in_ready"}, in_ready, 1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = early;
    a = ~av;
    b = ~bv;
    sign = ~sg;
    check({tag, "/busy"}, {busy, in_ready}, 2'b10);
    j = 0;
    while (!out_valid && j < 20) begin
      @(posedge clk);
      @(negedge clk);
      j++;
    end
    check({tag, "/latency"}, j, 4);
    check({tag, "/C"}, c, exp);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      @(negedge clk);
      check({tag, "/hold"}, {out_valid, in_ready, c}, {2'b10, exp});
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "/release"}, {out_valid, in_ready, c}, {2'b01, exp});
  endtask
  task automatic sweep(input logic sg, input logic [7:0] av, input logic [7:0] bv, input logic [15:0] a16v,
                       input logic [15:0] b16v, input logic [15:0] e8, input logic [31:0] e16);
    int lat [4];
    int need [4];
    need = '{8, 2, 1, 4};
    lat = '{0, 0, 0, 0};
    @(negedge clk);
    ss = sg;
    sa = av;
    sb = bv;
    a16 = a16v;
    b16 = b16v;
    sv = 1'b1;
    @(posedge clk);
    @(negedge clk);
    sv = 1'b0;
    for (int t = 1; t <= 12; t++) begin
      @(posedge clk);
      @(negedge clk);
      for (int d = 0; d < 4; d++)
        if (sov[d] && lat[d] == 0) lat[d] = t;
    end
    for (int d = 0; d < 4; d++) check($sformatf("sweep%0d/latency", d), lat[d], need[d]);
    for (int d = 0; d < 3; d++) check($sformatf("sweep%0d/C", d), sc[d], e8);
    check("sweep16/C", sc16, e16);
    sor = 1'b1;
    @(posedge clk);
    @(negedge clk);
    sor = 1'b0;
  endtask
  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end
  initial begin
    logic [7:0] ba [3];
    logic [7:0] bb [3];
    logic bs [3];
    logic [15:0] be [3];
    int vi, oi, last, spur;
    logic take;
    #12;
    check("reset", {in_ready, out_valid, busy, c}, {3'b100, 16'h0});
    @(negedge clk);
    rst_n = 1'b1;
    run(1'b0, 8'hFF, 8'hFF, 16'hFE01, 0, 1'b0, "uu_ff");
    run(1'b1, 8'h80, 8'h80, 16'h4000, 0, 1'b0, "ss_min");
    run(1'b1, 8'hFF, 8'h7F, 16'hFF81, 0, 1'b0, "ss_m127");
    run(1'b0, 8'h00, 8'h37, 16'h0000, 0, 1'b0, "zero_a");
    run(1'b1, 8'h5A, 8'h00, 16'h0000, 0, 1'b1, "zero_b_early");
    run(1'b0, 8'h12, 8'h34, 16'h03A8, 10, 1'b0, "backpressure");
    ba = '{8'd3, 8'hFD, 8'd200};
    bb = '{8'd5, 8'd5, 8'd3};
    bs = '{1'b0, 1'b1, 1'b0};
    be = '{16'h000F, 16'hFFF1, 16'h0258};
    out_ready = 1'b1;
    vi = 0;
    oi = 0;
    last = 0;
    @(negedge clk);
    sign = bs[0];
    a = ba[0];
    b = bb[0];
    in_valid = 1'b1;
    for (int t = 0; t < 60 && oi < 3; t++) begin
      if (out_valid) begin
        check($sformatf("b2b%0d/C", oi), c, be[oi]);
        if (oi > 0) check($sformatf("b2b%0d/gap", oi), t - last, 6);
        last = t;
        oi++;
      end
      take = in_valid && in_ready;
      @(posedge clk);
      @(negedge clk);
      if (take) begin
        vi++;
        if (vi < 3) begin
          sign = bs[vi];
          a = ba[vi];
          b = bb[vi];
        end else in_valid = 1'b0;
      end
    end
    check("b2b/count", oi, 3);
    out_ready = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    sign = 1'b0;
    a = 8'd7;
    b = 8'd9;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check("abort", {in_ready, out_valid, busy, c}, {3'b100, 16'h0});
    @(negedge clk);
    rst_n = 1'b1;
    spur = 0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid) spur++;
    end
    check("abort/no_spurious", spur, 0);
    run(1'b0, 8'd7, 8'd9, 16'h003F, 0, 1'b0, "after_abort");
    sweep(1'b1, 8'h80, 8'h7F, 16'h8000, 16'h8000, 16'hC080, 32'h40000000);
    sweep(1'b0, 8'hC8, 8'hFA, 16'hFFFF, 16'hFFFF, 16'hC350, 32'hFFFE0001);
    sweep(1'b1, 8'hF6, 8'hF9, 16'hFFFD, 16'h1234, 16'h0046, 32'hFFFFC964);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
